// File: rtl/ysyx_22041071_div_issue_pkg.sv
// Shared constants, state encodings and request payload for the divide issue controller.
package ysyx_22041071_div_issue_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned OP_BITS = 3;

  // Op-field bit positions
  localparam int unsigned OP_REM = 0;
  localparam int unsigned OP_UNS = 1;
  localparam int unsigned OP_W   = 2;

  // Controller states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [63:0] MIN_NEG64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN_NEG32 = 32'h8000_0000;

  // Latched request payload
  typedef struct packed {
    logic [OP_BITS-1:0] op;
    logic [XLEN-1:0]    src1;
    logic [XLEN-1:0]    src2;
    logic [TAG_W-1:0]   tag;
  } div_req_t;

  // Sign-extend the low word to XLEN
  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
    return {{(XLEN-32){x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/ysyx_22041071_div_special.sv
// Detects divide-by-zero and signed overflow and produces their architectural result.
module ysyx_22041071_div_special
  import ysyx_22041071_div_issue_pkg::*;
(
  input  logic [OP_BITS-1:0] op,
  input  logic [XLEN-1:0]    src1,
  input  logic [XLEN-1:0]    src2,
  output logic               special_c,
  output logic [XLEN-1:0]    result_c
);

  logic is_w;
  logic is_signed;
  logic is_rem;
  logic div_zero;
  logic ovf;

  assign is_w      = op[OP_W];
  assign is_signed = !op[OP_UNS];
  assign is_rem    = op[OP_REM];

  // W-ops only look at the low word of each operand
  assign div_zero = is_w ? (src2[31:0] == 32'h0) : (src2 == '0);
  assign ovf      = is_signed &&
                    (is_w ? ((src1[31:0] == MIN_NEG32) && (src2[31:0] == 32'hFFFF_FFFF))
                          : ((src1 == MIN_NEG64) && (src2 == '1)));

  // Result before W sign-extension, which the caller applies
  always_comb begin
    special_c = 1'b0;
    result_c  = '0;
    if (div_zero) begin
      special_c = 1'b1;
      result_c  = is_rem ? src1 : '1;
    end else if (ovf) begin
      special_c = 1'b1;
      result_c  = is_rem ? '0 : src1;
    end
  end

endmodule

// File: rtl/ysyx_22041071_div_issue.sv
// Issue/writeback controller between the EXU and the iterative divider.
module ysyx_22041071_div_issue
  import ysyx_22041071_div_issue_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OP_BITS-1:0] req_op,
  input  logic [XLEN-1:0]    req_src1,
  input  logic [XLEN-1:0]    req_src2,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XLEN-1:0]    resp_data,
  output logic [TAG_W-1:0]   resp_tag,
  output logic               div_valid,
  output logic               div_signed,
  output logic               divw,
  output logic [XLEN-1:0]    dividend,
  output logic [XLEN-1:0]    divisor,
  output logic               div_flush,
  input  logic               div_ready,
  input  logic               div_out_valid,
  input  logic [XLEN-1:0]    div_quot,
  input  logic [XLEN-1:0]    div_rema,
  output logic               busy
);

  logic [2:0]      state_q;
  logic [2:0]      state_d;
  div_req_t        req_q;
  logic [XLEN-1:0] res_q;

  logic            special_c;
  logic [XLEN-1:0] special_res_c;
  logic            accept_c;
  logic            capture_c;
  logic [XLEN-1:0] div_sel_c;

  // Special cases are evaluated on the incoming operands so they resolve at accept
  ysyx_22041071_div_special u_special (
    .op        (req_op),
    .src1      (req_src1),
    .src2      (req_src2),
    .special_c (special_c),
    .result_c  (special_res_c)
  );

  assign accept_c  = (state_q == S_IDLE) && req_valid && !flush;
  assign capture_c = (state_q == S_WAIT) && div_out_valid && !flush;
  assign div_sel_c = req_q.op[OP_REM] ? div_rema : div_quot;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = special_c ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (flush)          state_d = S_IDLE;
        else if (div_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // The divider cannot abort: a flush before the pulse must drain it
        if (flush)              state_d = div_out_valid ? S_IDLE : S_DRAIN;
        else if (div_out_valid) state_d = S_RESP;
      end
      S_DRAIN: begin
        // Flush is a no-op here; only the divider pulse ends the drain
        if (div_out_valid) state_d = S_IDLE;
      end
      S_RESP: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch and result capture (special result at accept, divider result on its pulse)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
      res_q <= '0;
    end else begin
      if (accept_c) begin
        req_q.op   <= req_op;
        req_q.src1 <= req_src1;
        req_q.src2 <= req_src2;
        req_q.tag  <= req_tag;
        if (special_c) res_q <= req_op[OP_W] ? sext_w(special_res_c) : special_res_c;
      end
      if (capture_c) res_q <= req_q.op[OP_W] ? sext_w(div_sel_c) : div_sel_c;
    end
  end

  // Output decode from registered state and payload
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign div_valid  = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign resp_data  = res_q;
  assign resp_tag   = req_q.tag;
  assign div_signed = !req_q.op[OP_UNS];
  assign divw       = req_q.op[OP_W];
  assign dividend   = req_q.src1;
  assign divisor    = req_q.src2;
  assign div_flush  = flush;

endmodule

// File: tb/tb_ysyx_22041071_div_issue.sv
// Randomized scoreboard bench for the divide issue controller with a behavioural divider.
`timescale 1ns/1ps
module tb_ysyx_22041071_div_issue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [63:0] req_src1;
  logic [63:0] req_src2;
  logic [4:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_tag;
  logic        div_valid;
  logic        div_signed;
  logic        divw;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        div_flush;
  logic        div_ready;
  logic        div_out_valid;
  logic [63:0] div_quot;
  logic [63:0] div_rema;
  logic        busy;

  ysyx_22041071_div_issue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
    .div_valid(div_valid), .div_signed(div_signed), .divw(divw),
    .dividend(dividend), .divisor(divisor), .div_flush(div_flush),
    .div_ready(div_ready), .div_out_valid(div_out_valid),
    .div_quot(div_quot), .div_rema(div_rema), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    bit          special;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  bit   flush_en = 0;
  bit   flush_force = 0;
  bit   bp_hold = 0;
  int   dm_lat_min = 0;
  int   dm_lat_max = 5;
  int   dm_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
  endtask

  // RV64M architectural result
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    bit rem, uns;
    rem = op[0];
    uns = op[1];
    if (op[2]) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'h0)                                           r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (!uns && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'h0 : a32;
      else if (uns)                                               r32 = rem ? a32 % b32 : a32 / b32;
      else r32 = rem ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'h0)                                                 r = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = rem ? 64'h0 : a;
    else if (uns)                                                   r = rem ? a % b : a / b;
    else r = rem ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    return r;
  endfunction

  function automatic bit ref_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (op[2]) return (b32 == 32'h0) || (!op[1] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
    return (b == 64'h0) || (!op[1] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  // Divider behaviour; upper bits of W results are junk so the controller must sign-extend
  task automatic div_compute(input logic sgn, input logic w, input logic [63:0] x, input logic [63:0] y,
                             output logic [63:0] q, output logic [63:0] r);
    logic [31:0] x32, y32, q32, r32;
    x32 = x[31:0];
    y32 = y[31:0];
    if (w) begin
      if (y32 == 32'h0) begin q32 = 32'hFFFF_FFFF; r32 = x32; end
      else if (sgn) begin
        q32 = 32'($signed(x32) / $signed(y32));
        r32 = 32'($signed(x32) % $signed(y32));
      end else begin
        q32 = x32 / y32;
        r32 = x32 % y32;
      end
      q = {32'($urandom), q32};
      r = {32'($urandom), r32};
    end else begin
      if (y == 64'h0) begin q = 64'hFFFF_FFFF_FFFF_FFFF; r = x; end
      else if (sgn) begin
        q = 64'($signed(x) / $signed(y));
        r = 64'($signed(x) % $signed(y));
      end else begin
        q = x / y;
        r = x % y;
      end
    end
  endtask

  // Iterative divider model: samples mid-cycle, updates just after the rising edge
  initial begin : divider_model
    logic s_hs, s_sgn, s_w;
    logic [63:0] s_dvd, s_dvs, pq, pr;
    bit busy_m;
    int cnt, cool;
    busy_m = 0; cnt = 0; cool = 0; pq = '0; pr = '0;
    div_ready = 1'b1; div_out_valid = 1'b0; div_quot = '0; div_rema = '0;
    forever begin
      @(negedge clk);
      s_hs = div_valid && div_ready;
      s_sgn = div_signed; s_w = divw; s_dvd = dividend; s_dvs = divisor;
      @(posedge clk); #1;
      if (!reset) begin
        busy_m = 0; cool = 0; div_ready = 1'b1; div_out_valid = 1'b0;
      end else if (s_hs) begin
        div_compute(s_sgn, s_w, s_dvd, s_dvs, pq, pr);
        busy_m = 1; cnt = $urandom_range(dm_lat_max, dm_lat_min);
        div_ready = 1'b0; div_out_valid = 1'b0;
      end else if (busy_m) begin
        if (cnt == 0) begin
          div_out_valid = 1'b1; div_quot = pq; div_rema = pr;
          busy_m = 0; cool = $urandom_range(2, 0); dm_pulses++;
        end else begin
          cnt--;
          div_out_valid = 1'b0;
        end
      end else begin
        div_out_valid = 1'b0;
        div_quot = 64'($urandom); div_rema = 64'($urandom);
        if (cool > 0) cool--;
        div_ready = (cool == 0);
      end
    end
  end

  // Flush and response-ready drivers
  initial begin
    flush = 1'b0;
    forever begin
      @(posedge clk); #2;
      flush = flush_en ? ($urandom_range(19, 0) == 0) : flush_force;
    end
  end

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      resp_ready = bp_hold ? 1'b0 : ($urandom_range(3, 0) != 0);
    end
  end

  // Monitor: compares presented results against the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
    end else begin
      check("busy_vs_req_ready", busy, !req_ready);
      check("div_flush", div_flush, flush);
      if (sb_q.size() > 0 && sb_q[0].special) check("special_no_div_valid", div_valid, 1'b0);
      if (resp_valid) begin
        if (sb_q.size() == 0) check("spurious_resp_valid", resp_valid, 1'b0);
        else begin
          check("resp_data", resp_data, sb_q[0].data);
          check("resp_tag", resp_tag, sb_q[0].tag);
          check("req_ready_in_resp", req_ready, 1'b0);
          if (resp_ready && !flush) void'(sb_q.pop_front());
        end
      end
      if (flush) sb_q.delete();
    end
  end

  // Present one op, push its expectation when accepted; entered and left just after a rising edge
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag);
    bit done;
    exp_t e;
    done = 0;
    req_op = op; req_src1 = a; req_src2 = b; req_tag = tag; req_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (req_ready && !flush && reset) begin
        done = 1;
        e.data = ref_result(op, a, b); e.tag = tag; e.special = ref_special(op, a, b);
        sb_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    else if (e.special) begin
      @(negedge clk);
      check("special_latency", resp_valid, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && req_ready) done = 1;
    end
    @(posedge clk); #1;
    if (!done) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_div_handshake(output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (div_valid && div_ready) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) check("div_handshake_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(6, 0))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return {32'($urandom), 32'h8000_0000};
      4: return 64'($urandom_range(300, 0));
      5: return -64'($urandom_range(300, 1));
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int pulses_before;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
    #12;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_div_valid", div_valid, 1'b0);
    check("reset_resp_data", resp_data, 64'h0);
    check("reset_busy", busy, 1'b0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Directed ops
    issue(3'b000, 64'd100, 64'd7, 5'd3);                            wait_idle(100);
    issue(3'b001, -64'd7, 64'd2, 5'd4);                             wait_idle(100);
    issue(3'b010, 64'h1234, 64'h0, 5'd5);                           wait_idle(100);
    issue(3'b011, 64'h1234, 64'h0, 5'd6);                           wait_idle(100);
    issue(3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7); wait_idle(100);
    issue(3'b101, 64'h8000_0000, 64'hFFFF_FFFF, 5'd8);              wait_idle(100);
    issue(3'b110, 64'h0000_0000_8000_0000, 64'd1, 5'd9);            wait_idle(100);
    issue(3'b101, -64'd9, 64'd4, 5'd10);                            wait_idle(100);

    // Flush mid-division: drain the divider, then a clean op
    dm_lat_min = 6; dm_lat_max = 8;
    issue(3'b000, 64'd1000, 64'd3, 5'd11);
    wait_div_handshake(ok);
    pulses_before = dm_pulses;
    flush_force = 1'b1;
    @(posedge clk); #1;
    flush_force = 1'b0;
    @(negedge clk);
    check("drain_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    wait_idle(100);
    check("drain_waited_for_pulse", 64'(dm_pulses), 64'(pulses_before + 1));
    dm_lat_min = 0; dm_lat_max = 5;
    issue(3'b000, 64'd50, 64'd5, 5'd12);                            wait_idle(100);

    // Backpressure in RESP
    bp_hold = 1'b1;
    issue(3'b100, 64'd200, 64'd9, 5'd13);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (resp_valid) ok = 1;
    end
    check("bp_resp_valid_seen", ok, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_held", resp_valid, 1'b1);
    end
    @(posedge clk); #1;
    bp_hold = 1'b0;
    wait_idle(100);

    // Reset while waiting on the divider
    dm_lat_min = 8; dm_lat_max = 10;
    issue(3'b011, 64'd12345, 64'd77, 5'd14);
    wait_div_handshake(ok);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("wait_reset_req_ready", req_ready, 1'b1);
    check("wait_reset_resp_valid", resp_valid, 1'b0);
    check("wait_reset_div_valid", div_valid, 1'b0);
    check("wait_reset_resp_data", resp_data, 64'h0);
    check("wait_reset_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    dm_lat_min = 0; dm_lat_max = 5;
    issue(3'b111, 64'hFFFF_FFFF_FFFF_FFF7, 64'd4, 5'd15);           wait_idle(100);

    // Random traffic with random flushes
    flush_en = 1;
    for (int n = 0; n < 250; n++) begin
      issue(3'($urandom_range(7, 0)), rand_operand(), rand_operand(), 5'($urandom));
      wait_idle(300);
    end
    flush_en = 0;
    wait_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22041071_div_issue.md
Name: ysyx_22041071_div_issue

Overview:
Issue/writeback controller between the EXU and the iterative divider. Accepts one decoded RV64M divide/remainder op per handshake and resolves divide-by-zero and signed overflow itself in one cycle. All other ops go to the divider, whose one-cycle result pulse is captured, quotient or remainder selected, and the result held for the EXU with a valid/ready handshake. Also owns flush semantics, because the divider cannot abort a running division.

Parameters:
XLEN, 64, operand/result width
TAG_W, 5, width of the pass-through destination tag (rd index)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-low reset
flush  input  1  pipeline flush; kills the in-flight op
req_valid  input  1  EXU presents an op
req_ready  output  1  block can accept an op
req_op  input  3  bit0 rem(1)/div(0), bit1 unsigned, bit2 word (W-op)
req_src1  input  XLEN  dividend
req_src2  input  XLEN  divisor
req_tag  input  TAG_W  destination tag
resp_valid  output  1  result available
resp_ready  input  1  EXU consumes result
resp_data  output  XLEN  final result, sign-extended for W-ops
resp_tag  output  TAG_W  tag of the result
div_valid  output  1  to divider: operands valid
div_signed  output  1  to divider
divw  output  1  to divider
dividend  output  XLEN  to divider, held stable while div_valid
divisor  output  XLEN  to divider, held stable while div_valid
div_flush  output  1  to divider, equals flush
div_ready  input  1  divider idle
div_out_valid  input  1  divider one-cycle result pulse
div_quot  input  XLEN  divider quotient
div_rema  input  XLEN  divider remainder
busy  output  1  stall request to the pipeline, high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous) forces state IDLE and clears op/tag/operand/result registers. Output values during reset: req_ready=1, resp_valid=0, div_valid=0, resp_data=0, busy=0.
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid && !flush, latch op, src1, src2 and tag.
  - Special case → RESP next cycle with the precomputed result.
  - Otherwise → ISSUE.
- Special cases. Operands are the low 32 bits for W-ops.
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed op with dividend==most-negative and divisor==-1: quotient = dividend; remainder = 0.
- ISSUE: div_valid=1, with dividend/divisor/div_signed/divw driven from the latched registers.
  - If div_ready=1 → WAIT.
  - If div_ready=0 (divider still busy), stay in ISSUE.
- WAIT: on div_out_valid, capture div_rema if rem, else div_quot → RESP. Capture must happen in that same cycle because the pulse lasts one cycle.
- RESP: resp_valid=1; resp_data and resp_tag held stable. On resp_ready → IDLE. The next request can be accepted the cycle after.
- W-ops: resp_data = sign-extension of result[31:0]. This applies to all W-ops, including divuw and remuw.
- Flush handling by state (flush has priority over every other transition):
  - IDLE, ISSUE, RESP: go to IDLE; resp is dropped.
  - WAIT: go to DRAIN.
  - DRAIN: req_ready=0; wait for div_out_valid, discard the result, → IDLE. A flush while in DRAIN keeps the state DRAIN.
- A flush in the same cycle as req_valid prevents acceptance.
- div_valid is never asserted outside ISSUE.
- Latency:
  - Special case: resp_valid in the cycle after acceptance.
  - Normal: acceptance → ISSUE (1 cycle) → divider latency → resp_valid in the cycle after div_out_valid.
- Simultaneous div_out_valid and flush in WAIT: the result is discarded → IDLE.

Decomposition:
- Shared package holds:
  - op-field bit positions: OP_REM=0, OP_UNS=1, OP_W=2
  - state encodings
  - XLEN
  - constant MIN_NEG64 = 64'h8000_0000_0000_0000
  - constant MIN_NEG32 = 32'h8000_0000
- One natural sub-module, ysyx_22041071_div_special. It is combinational: op + operands → special flag + special result.

Test Plan:
- div 100/7, signed: quotient path. → resp_data=14 after div_out_valid; tag echoed. rem -7 % 2 → resp_data=64'hFFFF_FFFF_FFFF_FFFF.
- divu x/0 with x=0x1234 → resp_data=all ones one cycle after accept; div_valid never asserted. remu x/0 → 0x1234.
- div 0x8000_0000_0000_0000 / -1 → resp_data=0x8000_0000_0000_0000, no divider use. remw 0x8000_0000/0xFFFF_FFFF → 0.
- divuw src1=0x0000_0000_8000_0000, src2=1 → resp_data=0xFFFF_FFFF_8000_0000. remw -9/4 → 0xFFFF_FFFF_FFFF_FFFF.
- Flush in WAIT mid-division: no resp_valid; req_ready=0 until div_out_valid; the next request 50/5 then returns 10.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_data/resp_tag stable, req_ready=0. Also assert reset during WAIT → all outputs return to their reset values immediately.
